// File: rtl/f18a_vram_arb_pkg.sv
// Shared types for the F18A VRAM port arbiter: requester ids, read tags
// and the pause-handshake states.
package f18a_vram_arb_pkg;

   localparam int ADDR_W_DEF = 14;
   localparam int DATA_W_DEF = 8;

   typedef logic req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } tag_t;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      PAUSED
   } pause_state_t;

endpackage

// File: rtl/f18a_rr_arb2.sv
// Two-way round-robin picker: the requester that did not win last time
// takes priority when both are eligible.
module f18a_rr_arb2
   import f18a_vram_arb_pkg::*;
(
   input  logic [1:0] i_elig,
   input  req_id_t    i_last,
   output logic [1:0] o_win,
   output req_id_t    o_next_last
);

   always_comb begin
      o_win       = 2'b00;
      o_next_last = i_last;
      case (i_elig)
         2'b01: begin
            o_win       = 2'b01;
            o_next_last = 1'b0;
         end
         2'b10: begin
            o_win       = 2'b10;
            o_next_last = 1'b1;
         end
         2'b11: begin
            o_win       = i_last ? 2'b01 : 2'b10;
            o_next_last = ~i_last;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/f18a_vram_arb.sv
// Shares the F18A GPU-side VRAM port between two requesters, routes read
// data back by tag, and drains outstanding reads before acknowledging pause.
module f18a_vram_arb
   import f18a_vram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_LAT = 1
) (
   input  logic                   clk_logic_i,
   input  logic                   reset_n_i,
   input  logic [1:0]             req_i,
   input  logic [1:0]             we_i,
   input  logic [1:0][ADDR_W-1:0] addr_i,
   input  logic [1:0][DATA_W-1:0] wdata_i,
   output logic [1:0]             gnt_o,
   output logic [1:0]             rvalid_o,
   output logic [DATA_W-1:0]      rdata_o,
   output logic [ADDR_W-1:0]      vaddr_o,
   output logic                   vwe_o,
   output logic [DATA_W-1:0]      vdout_o,
   input  logic [DATA_W-1:0]      vdin_i,
   input  logic                   pause_i,
   output logic                   pause_ack_o
);

   logic [1:0]        r_gnt;
   logic [ADDR_W-1:0] r_vaddr;
   logic [DATA_W-1:0] r_vdout;
   logic              r_vwe;
   req_id_t           r_last;
   tag_t [RD_LAT-1:0] r_tag;
   pause_state_t      r_state;

   pause_state_t w_next_state;
   logic [1:0]   w_elig;
   logic [1:0]   w_win;
   req_id_t      w_next_last;
   req_id_t      w_win_id;
   tag_t         w_push;
   tag_t         w_out;
   logic         w_pending;
   logic         w_drained;
   logic         w_ack;

   // A request just served is masked so a held req is not re-granted at once.
   assign w_ack    = (r_state == PAUSED);
   assign w_elig   = req_i & ~r_gnt & {2{~pause_i & ~w_ack}};
   assign w_win_id = w_win[1];

   f18a_rr_arb2 u_rr (
      .i_elig      (w_elig),
      .i_last      (r_last),
      .o_win       (w_win),
      .o_next_last (w_next_last)
   );

   always_ff @(posedge clk_logic_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_gnt   <= 2'b00;
         r_vaddr <= '0;
         r_vdout <= '0;
         r_vwe   <= 1'b0;
         r_last  <= 1'b1;
      end else if (|w_win) begin
         r_gnt   <= w_win;
         r_vaddr <= addr_i[w_win_id];
         r_vdout <= wdata_i[w_win_id];
         r_vwe   <= we_i[w_win_id];
         r_last  <= w_next_last;
      end else begin
         r_gnt <= 2'b00;
         r_vwe <= 1'b0;
      end
   end

   assign w_push.valid = (|r_gnt) & ~r_vwe;
   assign w_push.id    = r_gnt[1];

   always_ff @(posedge clk_logic_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_tag <= '0;
      end else begin
         r_tag[0] <= w_push;
         for (int k = 1; k < RD_LAT; k++) begin
            r_tag[k] <= r_tag[k-1];
         end
      end
   end

   // The tag in the last stage returns this cycle, so it no longer counts as outstanding.
   always_comb begin
      w_pending = 1'b0;
      for (int k = 0; k < RD_LAT - 1; k++) begin
         w_pending = w_pending | r_tag[k].valid;
      end
   end

   assign w_drained = ~w_pending & ~(|r_gnt);

   always_ff @(posedge clk_logic_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         RUN: begin
            if (pause_i) begin
               w_next_state = w_drained ? PAUSED : DRAIN;
            end
         end
         DRAIN: begin
            if (!pause_i) begin
               w_next_state = RUN;
            end else if (w_drained) begin
               w_next_state = PAUSED;
            end
         end
         PAUSED: begin
            if (!pause_i) begin
               w_next_state = RUN;
            end
         end
         default: w_next_state = RUN;
      endcase
   end

   assign w_out       = r_tag[RD_LAT-1];
   assign rvalid_o    = {w_out.valid & w_out.id, w_out.valid & ~w_out.id};
   assign rdata_o     = w_out.valid ? vdin_i : '0;
   assign gnt_o       = r_gnt;
   assign vaddr_o     = r_vaddr;
   assign vdout_o     = r_vdout;
   assign vwe_o       = r_vwe;
   assign pause_ack_o = w_ack;

endmodule

// File: tb/tb_f18a_vram_arb.sv
// Directed bench for the F18A VRAM arbiter with a two-cycle read latency
// memory model on the VDP side.
module tb_f18a_vram_arb;

   localparam int RD_LAT = 2;

   logic             clk = 1'b0;
   logic             resetN;
   logic [1:0]       req;
   logic [1:0]       we;
   logic [1:0][13:0] addr;
   logic [1:0][7:0]  wdata;
   logic [1:0]       gnt;
   logic [1:0]       rvalid;
   logic [7:0]       rdata;
   logic [13:0]      vaddr;
   logic             vwe;
   logic [7:0]       vdout;
   logic [7:0]       vdin;
   logic             pauseIn;
   logic             pauseAck;

   int vecCount  = 0;
   int failCount = 0;

   logic [13:0] addrPipe [RD_LAT] = '{default: 14'h0};

   f18a_vram_arb #(
      .ADDR_W (14),
      .DATA_W (8),
      .RD_LAT (RD_LAT)
   ) u_dut (
      .clk_logic_i (clk),
      .reset_n_i   (resetN),
      .req_i       (req),
      .we_i        (we),
      .addr_i      (addr),
      .wdata_i     (wdata),
      .gnt_o       (gnt),
      .rvalid_o    (rvalid),
      .rdata_o     (rdata),
      .vaddr_o     (vaddr),
      .vwe_o       (vwe),
      .vdout_o     (vdout),
      .vdin_i      (vdin),
      .pause_i     (pauseIn),
      .pause_ack_o (pauseAck)
   );

   always #5 clk = ~clk;

   // VDP-side memory: data for the address issued RD_LAT cycles earlier.
   function automatic logic [7:0] memData(input logic [13:0] a);
      if (a == 14'h0800) return 8'h3C;
      return a[7:0] ^ 8'h5A;
   endfunction

   always @(posedge clk) begin
      addrPipe[0] <= vaddr;
      for (int k = 1; k < RD_LAT; k++) addrPipe[k] <= addrPipe[k-1];
   end

   assign vdin = memData(addrPipe[RD_LAT-1]);

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                                input logic [13:0] a0, input logic [13:0] a1,
                                input logic [7:0] d0, input logic [7:0] d1);
      req      = r;
      we       = w;
      addr[0]  = a0;
      addr[1]  = a1;
      wdata[0] = d0;
      wdata[1] = d1;
   endtask

   task automatic doReset();
      resetN = 1'b0;
      step();
      step();
      resetN = 1'b1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_gnt"},    32'(gnt),      32'h0);
      checkOutput({tag, "_rvalid"}, 32'(rvalid),   32'h0);
      checkOutput({tag, "_rdata"},  32'(rdata),    32'h0);
      checkOutput({tag, "_vaddr"},  32'(vaddr),    32'h0);
      checkOutput({tag, "_vwe"},    32'(vwe),      32'h0);
      checkOutput({tag, "_vdout"},  32'(vdout),    32'h0);
      checkOutput({tag, "_ack"},    32'(pauseAck), 32'h0);
   endtask

   logic [1:0] expGnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

   initial begin
      pauseIn = 1'b0;
      applyStimulus(2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0);
      resetN = 1'b0;
      step();
      checkAllZero("reset");
      doReset();

      // single write, held request must not be re-granted
      applyStimulus(2'b01, 2'b01, 14'h1234, 14'h0, 8'hA5, 8'h0);
      step();
      checkOutput("wr_gnt",   32'(gnt),   32'h1);
      checkOutput("wr_vaddr", 32'(vaddr), 32'h1234);
      checkOutput("wr_vdout", 32'(vdout), 32'hA5);
      checkOutput("wr_vwe",   32'(vwe),   32'h1);
      step();
      checkOutput("wr_regnt", 32'(gnt),   32'h0);
      checkOutput("wr_vwe0",  32'(vwe),   32'h0);
      checkOutput("wr_hold",  32'(vaddr), 32'h1234);
      applyStimulus(2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0);
      step();
      checkOutput("wr_idle", 32'(gnt), 32'h0);

      // both requesters writing continuously alternate every cycle
      doReset();
      applyStimulus(2'b11, 2'b11, 14'h0100, 14'h0200, 8'h11, 8'h22);
      for (int i = 0; i < 4; i++) begin
         step();
         checkOutput($sformatf("alt_gnt%0d", i),   32'(gnt),   32'(expGnt[i]));
         checkOutput($sformatf("alt_vwe%0d", i),   32'(vwe),   32'h1);
         checkOutput($sformatf("alt_vaddr%0d", i), 32'(vaddr), expGnt[i][0] ? 32'h0100 : 32'h0200);
         checkOutput($sformatf("alt_rv%0d", i),    32'(rvalid), 32'h0);
      end
      applyStimulus(2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0);
      step();
      checkOutput("alt_stop", 32'(gnt), 32'h0);

      // read by requester 1 with a write in between
      applyStimulus(2'b10, 2'b00, 14'h0, 14'h0800, 8'h0, 8'h0);
      step();
      checkOutput("rd_gnt", 32'(gnt), 32'h2);
      applyStimulus(2'b01, 2'b01, 14'h0010, 14'h0800, 8'h55, 8'h0);
      step();
      checkOutput("rd_wgnt",  32'(gnt),    32'h1);
      checkOutput("rd_wvwe",  32'(vwe),    32'h1);
      checkOutput("rd_early", 32'(rvalid), 32'h0);
      applyStimulus(2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0);
      step();
      checkOutput("rd_rvalid", 32'(rvalid), 32'h2);
      checkOutput("rd_rdata",  32'(rdata),  32'h3C);
      step();
      checkOutput("rd_wr_norv", 32'(rvalid), 32'h0);

      // three pipelined reads, then pause drains them
      applyStimulus(2'b01, 2'b00, 14'h0020, 14'h0, 8'h0, 8'h0);
      step();
      checkOutput("pr_gnt0", 32'(gnt), 32'h1);
      applyStimulus(2'b10, 2'b00, 14'h0020, 14'h0030, 8'h0, 8'h0);
      step();
      checkOutput("pr_gnt1", 32'(gnt), 32'h2);
      applyStimulus(2'b01, 2'b00, 14'h0040, 14'h0030, 8'h0, 8'h0);
      step();
      checkOutput("pr_gnt2", 32'(gnt),    32'h1);
      checkOutput("pr_rv0",  32'(rvalid), 32'h1);
      checkOutput("pr_rd0",  32'(rdata),  32'h7A);
      applyStimulus(2'b00, 2'b00, 14'h0040, 14'h0030, 8'h0, 8'h0);
      step();
      checkOutput("pr_rv1",  32'(rvalid),   32'h2);
      checkOutput("pr_rd1",  32'(rdata),    32'h6A);
      checkOutput("pr_ack0", 32'(pauseAck), 32'h0);
      pauseIn = 1'b1;
      applyStimulus(2'b10, 2'b10, 14'h0040, 14'h0050, 8'h0, 8'h77);
      step();
      checkOutput("pr_nognt", 32'(gnt),      32'h0);
      checkOutput("pr_rv2",   32'(rvalid),   32'h1);
      checkOutput("pr_rd2",   32'(rdata),    32'h1A);
      checkOutput("pr_ack1",  32'(pauseAck), 32'h0);
      step();
      checkOutput("pr_ack2",  32'(pauseAck), 32'h1);
      checkOutput("pr_rvend", 32'(rvalid),   32'h0);
      checkOutput("pr_gntp",  32'(gnt),      32'h0);
      step();
      checkOutput("pr_ack3", 32'(pauseAck), 32'h1);
      pauseIn = 1'b0;
      step();
      checkOutput("pr_ackdn", 32'(pauseAck), 32'h0);
      checkOutput("pr_gntdn", 32'(gnt),      32'h0);
      step();
      checkOutput("pr_resume", 32'(gnt),   32'h2);
      checkOutput("pr_rsaddr", 32'(vaddr), 32'h0050);
      checkOutput("pr_rsdout", 32'(vdout), 32'h77);
      applyStimulus(2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0);
      step();

      // pause while idle, request raised during pause
      pauseIn = 1'b1;
      step();
      checkOutput("ip_ack", 32'(pauseAck), 32'h1);
      applyStimulus(2'b01, 2'b01, 14'h0060, 14'h0, 8'h99, 8'h0);
      step();
      checkOutput("ip_nognt", 32'(gnt), 32'h0);
      pauseIn = 1'b0;
      step();
      checkOutput("ip_ackdn", 32'(pauseAck), 32'h0);
      checkOutput("ip_gnt1",  32'(gnt),      32'h0);
      step();
      checkOutput("ip_gnt2",  32'(gnt),   32'h1);
      checkOutput("ip_vaddr", 32'(vaddr), 32'h0060);
      applyStimulus(2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0);
      step();

      // reset with a read in flight
      applyStimulus(2'b10, 2'b00, 14'h0, 14'h0070, 8'h0, 8'h0);
      step();
      checkOutput("rst_gnt", 32'(gnt), 32'h2);
      applyStimulus(2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0);
      step();
      resetN = 1'b0;
      #1;
      checkAllZero("rst_async");
      step();
      step();
      resetN = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput($sformatf("rst_norv%0d", i), 32'(rvalid), 32'h0);
      end
      applyStimulus(2'b11, 2'b11, 14'h0100, 14'h0200, 8'h0, 8'h0);
      step();
      checkOutput("rst_first", 32'(gnt), 32'h1);
      applyStimulus(2'b00, 2'b00, 14'h0, 14'h0, 8'h0, 8'h0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
      $finish;
   end

endmodule
